// File: rtl/bkram_sd_ctrl.sv
// Backup-RAM <-> SD sector transfer controller.
// Loads the save image sector by sector when an image is mounted and writes
// it back on a user save request.
//
// Optional feature (macro BKRAM_DIRTY_TRACK_EN): per-sector dirty map fed by
// cpu_wr; SAVE then only writes sectors touched since the last load/save.
//
// Ports:
//   clk_sys, RESET_n         clock, asynchronous active-low reset
//   img_mounted, img_size    mount strobe (rising edge) and image size in bytes
//   dl_active                ROM download in progress (rising edge aborts)
//   save_req                 user save request (rising edge)
//   cpu_wr, cpu_addr         core backup-RAM write strobe and byte address
//   sd_lba, sd_rd, sd_wr     SD sector request
//   sd_ack                   SD transfer acknowledge (high during transfer)
//   sect                     current sector index (buffer address high bits)
//   bk_ena, busy, bk_reset   image valid, sequence running, load-done pulse
module bkram_sd_ctrl #(
  parameter int unsigned SECT_BITS = 4,
  parameter logic [31:0] LBA_BASE  = 32'd0
) (
  input  logic                   clk_sys,
  input  logic                   RESET_n,
  input  logic                   img_mounted,
  input  logic [31:0]            img_size,
  input  logic                   dl_active,
  input  logic                   save_req,
  input  logic                   cpu_wr,
  input  logic [SECT_BITS+8:0]   cpu_addr,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  output logic [SECT_BITS-1:0]   sect,
  output logic                   bk_ena,
  output logic                   busy,
  output logic                   bk_reset
);

  localparam int unsigned NS_W = SECT_BITS + 1;
  localparam int unsigned DW   = 2 ** SECT_BITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_NEXT = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [SECT_BITS-1:0] sect_q, sect_d;
  logic [NS_W-1:0]      n_sect_q, n_sect_d;
  logic [31:0]          sd_lba_q, sd_lba_d;
  logic                 sd_rd_q, sd_rd_d;
  logic                 sd_wr_q, sd_wr_d;
  logic                 bk_ena_q, bk_ena_d;
  logic                 busy_q, busy_d;
  logic                 bk_reset_q, bk_reset_d;
  logic                 pending_q, pending_d;
  logic                 is_save_q, is_save_d;
  logic                 abort_q, abort_d;
  logic [3:0]           hist_q, hist_d;

  logic                 mount_rise, save_rise, dl_rise, ack_rise, ack_fall;
  logic                 size_nz, start, more, first_clean, nxt_clean;
  logic [23:0]          size_sect;
  logic [NS_W-1:0]      n_sect_calc;
  logic [NS_W-1:0]      sect_nxt_w;
  logic [SECT_BITS-1:0] sect_nxt;
  logic                 unused_cpu;

  // Port inputs not needed in every build
  assign unused_cpu = ^{cpu_wr, cpu_addr};

  // One-cycle history for edge detection
  assign hist_d     = {img_mounted, save_req, dl_active, sd_ack};
  assign mount_rise = img_mounted & ~hist_q[3];
  assign save_rise  = save_req    & ~hist_q[2];
  assign dl_rise    = dl_active   & ~hist_q[1];
  assign ack_rise   = sd_ack      & ~hist_q[0];
  assign ack_fall   = ~sd_ack     &  hist_q[0];

  // Sector count: ceil(size/512) clamped to the buffer size
  assign size_nz     = (img_size != 32'd0);
  assign size_sect   = 24'((33'(img_size) + 33'd511) >> 9);
  assign n_sect_calc = (size_sect > 24'(DW)) ? NS_W'(DW) : NS_W'(size_sect);

  assign sect_nxt_w = NS_W'(sect_q) + NS_W'(1);
  assign sect_nxt   = sect_q + SECT_BITS'(1);
  assign more       = (sect_nxt_w < n_sect_q);

`ifdef BKRAM_DIRTY_TRACK_EN
  logic [DW-1:0] dirty_q, dirty_d, dirty_set, dirty_clr;

  assign first_clean = ~dirty_q[0];
  assign nxt_clean   = ~dirty_q[sect_nxt];

  // Set wins over a same-cycle clear; a finished load resets the map
  always_comb begin
    dirty_set = '0;
    dirty_clr = '0;
    if (cpu_wr) dirty_set[cpu_addr[SECT_BITS+8:9]] = 1'b1;
    if (is_save_q && (state_q == ST_XFER) && ack_fall) dirty_clr[sect_q] = 1'b1;
    dirty_d = ((bk_reset_d) ? '0 : (dirty_q & ~dirty_clr)) | dirty_set;
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) dirty_q <= '0;
    else          dirty_q <= dirty_d;
  end
`else
  assign first_clean = 1'b0;
  assign nxt_clean   = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    sect_d     = sect_q;
    n_sect_d   = n_sect_q;
    sd_lba_d   = sd_lba_q;
    sd_rd_d    = sd_rd_q;
    sd_wr_d    = sd_wr_q;
    bk_ena_d   = bk_ena_q;
    bk_reset_d = 1'b0;
    pending_d  = pending_q;
    is_save_d  = is_save_q;
    abort_d    = abort_q;
    start      = 1'b0;

    if (mount_rise) begin
      n_sect_d = n_sect_calc;
      bk_ena_d = size_nz;
      // A mount during a sequence is queued; a zero-size mount cancels it
      if (state_q != ST_IDLE || !size_nz) pending_d = size_nz;
    end
    if (dl_rise) begin
      bk_ena_d  = 1'b0;
      pending_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        sd_rd_d = 1'b0;
        sd_wr_d = 1'b0;
        abort_d = 1'b0;
        if (!dl_rise) begin
          if (mount_rise ? size_nz : pending_q) begin
            start     = 1'b1;
            is_save_d = 1'b0;
            pending_d = 1'b0;
          end else if (save_rise && bk_ena_q) begin
            start     = 1'b1;
            is_save_d = 1'b1;
          end
        end
        if (start) begin
          sect_d   = '0;
          sd_lba_d = LBA_BASE;
          if (is_save_d && first_clean) begin
            state_d = ST_NEXT;
          end else begin
            state_d = ST_REQ;
            sd_rd_d = ~is_save_d;
            sd_wr_d = is_save_d;
          end
        end
      end
      ST_REQ: begin
        if (dl_rise) begin
          state_d = ST_IDLE;
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
        end else if (ack_rise) begin
          state_d = ST_XFER;
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
        end
      end
      ST_XFER: begin
        // A download start lets the running sector finish, then stops
        if (dl_rise) abort_d = 1'b1;
        if (ack_fall) state_d = (abort_q || dl_rise) ? ST_IDLE : ST_NEXT;
      end
      ST_NEXT: begin
        if (dl_rise) begin
          state_d = ST_IDLE;
        end else if (more) begin
          sect_d = sect_nxt;
          if (!(is_save_q && nxt_clean)) begin
            state_d  = ST_REQ;
            sd_lba_d = LBA_BASE + 32'(sect_nxt);
            sd_rd_d  = ~is_save_q;
            sd_wr_d  = is_save_q;
          end
        end else begin
          state_d    = ST_IDLE;
          bk_reset_d = ~is_save_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= ST_IDLE;
      sect_q     <= '0;
      n_sect_q   <= '0;
      sd_lba_q   <= LBA_BASE;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
      bk_ena_q   <= 1'b0;
      busy_q     <= 1'b0;
      bk_reset_q <= 1'b0;
      pending_q  <= 1'b0;
      is_save_q  <= 1'b0;
      abort_q    <= 1'b0;
      hist_q     <= '0;
    end else begin
      state_q    <= state_d;
      sect_q     <= sect_d;
      n_sect_q   <= n_sect_d;
      sd_lba_q   <= sd_lba_d;
      sd_rd_q    <= sd_rd_d;
      sd_wr_q    <= sd_wr_d;
      bk_ena_q   <= bk_ena_d;
      busy_q     <= busy_d;
      bk_reset_q <= bk_reset_d;
      pending_q  <= pending_d;
      is_save_q  <= is_save_d;
      abort_q    <= abort_d;
      hist_q     <= hist_d;
    end
  end

  assign sd_lba   = sd_lba_q;
  assign sd_rd    = sd_rd_q;
  assign sd_wr    = sd_wr_q;
  assign sect     = sect_q;
  assign bk_ena   = bk_ena_q;
  assign busy     = busy_q;
  assign bk_reset = bk_reset_q;

endmodule

// File: tb/tb_bkram_sd_ctrl.sv
// Testbench for bkram_sd_ctrl: SD card model, request scoreboard, mount table.
module tb_bkram_sd_ctrl;

  localparam int unsigned SB = 4;

  typedef struct packed { logic wr; logic [31:0] lba; } req_t;
  typedef struct { logic [31:0] size; int unsigned n; } vec_t;

  logic          clk_sys = 1'b0;
  logic          RESET_n;
  logic          img_mounted;
  logic [31:0]   img_size;
  logic          dl_active;
  logic          save_req;
  logic          cpu_wr;
  logic [SB+8:0] cpu_addr;
  logic [31:0]   sd_lba;
  logic          sd_rd;
  logic          sd_wr;
  logic          sd_ack;
  logic [SB-1:0] sect;
  logic          bk_ena;
  logic          busy;
  logic          bk_reset;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   rst_cycles = 0;
  int   bc;
  int   t;
  bit   sd_auto = 1'b1;
  int   ack_len = 3;
  req_t exp_q[$];
  vec_t vecs[7];

  bkram_sd_ctrl #(.SECT_BITS(SB), .LBA_BASE(32'd0)) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .img_mounted(img_mounted),
    .img_size(img_size), .dl_active(dl_active), .save_req(save_req),
    .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .sd_lba(sd_lba), .sd_rd(sd_rd),
    .sd_wr(sd_wr), .sd_ack(sd_ack), .sect(sect), .bk_ena(bk_ena),
    .busy(busy), .bk_reset(bk_reset)
  );

  always #5 clk_sys = ~clk_sys;

  // SD card: ack a request after 2 cycles, hold it ack_len cycles
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (sd_auto && (sd_rd || sd_wr)) begin
        repeat (2) @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (ack_len) @(negedge clk_sys);
        sd_ack = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pops the expected request on every new sd_rd/sd_wr assertion
  task automatic monitor();
    logic rd_p, wr_p;
    req_t e;
    rd_p = 1'b0;
    wr_p = 1'b0;
    forever begin
      @(negedge clk_sys);
      if ((sd_rd && !rd_p) || (sd_wr && !wr_p)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_req: got rd=%0b wr=%0b lba=%0d, expected no request",
                   sd_rd, sd_wr, sd_lba);
        end else begin
          e = exp_q.pop_front();
          chk("req_kind", {62'd0, sd_wr, sd_rd}, {62'd0, e.wr, ~e.wr});
          chk("req_lba", 64'(sd_lba), 64'(e.lba));
        end
      end
      if (bk_reset) rst_cycles++;
      rd_p = sd_rd;
      wr_p = sd_wr;
    end
  endtask

  task automatic push_seq(input logic wr, input int unsigned first, input int unsigned n);
    for (int i = 0; i < int'(n); i++) exp_q.push_back({wr, 32'(first + 32'(i))});
  endtask

  task automatic do_mount(input logic [31:0] sz);
    @(negedge clk_sys);
    img_size    = sz;
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
  endtask

  task automatic do_save();
    @(negedge clk_sys);
    save_req = 1'b1;
    @(negedge clk_sys);
    save_req = 1'b0;
  endtask

  task automatic do_cpu_wr(input logic [SB+8:0] a);
    @(negedge clk_sys);
    cpu_addr = a;
    cpu_wr   = 1'b1;
    @(negedge clk_sys);
    cpu_wr   = 1'b0;
  endtask

  // Run until every expected request is seen and the controller is idle
  task automatic wait_done(input string name, output int busy_cyc);
    int tt;
    tt = 0;
    busy_cyc = busy ? 1 : 0;
    while ((exp_q.size() != 0 || busy) && tt < 4000) begin
      @(negedge clk_sys);
      tt++;
      if (busy) busy_cyc++;
    end
    if (tt >= 4000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d, expected idle within 4000 cycles",
               name, busy, exp_q.size());
    end
    repeat (3) @(negedge clk_sys);
    chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{size: 32'd1000,   n: 2};
    vecs[1] = '{size: 32'd512,    n: 1};
    vecs[2] = '{size: 32'd513,    n: 2};
    vecs[3] = '{size: 32'd1,      n: 1};
    vecs[4] = '{size: 32'd7680,   n: 15};
    vecs[5] = '{size: 32'd100000, n: 16};
    vecs[6] = '{size: 32'd8192,   n: 16};

    RESET_n = 1'b0; img_mounted = 1'b0; img_size = '0; dl_active = 1'b0;
    save_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0;
    fork monitor(); join_none

    repeat (3) @(negedge clk_sys);
    chk("rst_sd_rd", 64'(sd_rd), 64'd0);
    chk("rst_sd_wr", 64'(sd_wr), 64'd0);
    chk("rst_sd_lba", 64'(sd_lba), 64'd0);
    chk("rst_sect", 64'(sect), 64'd0);
    chk("rst_bk_ena", 64'(bk_ena), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_bk_reset", 64'(bk_reset), 64'd0);
    RESET_n = 1'b1;
    @(negedge clk_sys);

    // Mount table: reads at LBA 0..n-1, one-cycle bk_reset, image enabled
    for (int i = 0; i < 7; i++) begin
      rst_cycles = 0;
      push_seq(1'b0, 0, vecs[i].n);
      do_mount(vecs[i].size);
      wait_done("load", bc);
      chk("load_bk_reset_cycles", 64'(rst_cycles), 64'd1);
      chk("load_bk_ena", 64'(bk_ena), 64'd1);
      chk("load_last_sect", 64'(sect), 64'(vecs[i].n - 1));
    end

    // Zero-size mount disables the image and starts nothing
    do_mount(32'd0);
    repeat (3) @(negedge clk_sys);
    chk("zero_mount_bk_ena", 64'(bk_ena), 64'd0);
    chk("zero_mount_busy", 64'(busy), 64'd0);
    rst_cycles = 0;
    push_seq(1'b0, 0, 16);
    do_mount(32'd8192);
    wait_done("reload", bc);
    chk("reload_bk_reset_cycles", 64'(rst_cycles), 64'd1);

    // SAVE right after a load
    rst_cycles = 0;
`ifndef BKRAM_DIRTY_TRACK_EN
    push_seq(1'b1, 0, 16);
`endif
    do_save();
    wait_done("save_clean", bc);
`ifdef BKRAM_DIRTY_TRACK_EN
    chk("save_clean_busy_le_n1", 64'(bc <= 17), 64'd1);
`endif
    chk("save_clean_no_bk_reset", 64'(rst_cycles), 64'd0);

    // Dirty sectors 0 and 6, then save twice
    do_cpu_wr(13'h0005);
    do_cpu_wr(13'h0C00);
`ifdef BKRAM_DIRTY_TRACK_EN
    push_seq(1'b1, 0, 1);
    push_seq(1'b1, 6, 1);
`else
    push_seq(1'b1, 0, 16);
`endif
    do_save();
    wait_done("save_dirty", bc);
`ifndef BKRAM_DIRTY_TRACK_EN
    push_seq(1'b1, 0, 16);
`endif
    do_save();
    wait_done("save_again", bc);

    // save_req during LOAD is dropped
    rst_cycles = 0;
    push_seq(1'b0, 0, 2);
    do_mount(32'd1000);
    repeat (2) @(negedge clk_sys);
    do_save();
    wait_done("load_with_save", bc);
    chk("load_with_save_bk_reset", 64'(rst_cycles), 64'd1);
    chk("load_with_save_busy", 64'(busy), 64'd0);

    // Mount during SAVE: LOAD follows once SAVE ends
    do_cpu_wr(13'h0200);
`ifdef BKRAM_DIRTY_TRACK_EN
    push_seq(1'b1, 1, 1);
`else
    push_seq(1'b1, 0, 2);
`endif
    push_seq(1'b0, 0, 2);
    rst_cycles = 0;
    do_save();
    do_mount(32'd1000);
    wait_done("save_then_load", bc);
    chk("save_then_load_bk_reset", 64'(rst_cycles), 64'd1);
    chk("save_then_load_bk_ena", 64'(bk_ena), 64'd1);

    // dl_active rising while a SAVE waits in REQ
    push_seq(1'b0, 0, 16);
    do_mount(32'd8192);
    wait_done("pre_abort_load", bc);
    sd_auto = 1'b0;
    do_cpu_wr(13'h0000);
    push_seq(1'b1, 0, 1);
    rst_cycles = 0;
    do_save();
    t = 0;
    while (!sd_wr && t < 50) begin
      @(negedge clk_sys);
      t++;
    end
    chk("abort_wr_seen", 64'(sd_wr), 64'd1);
    dl_active = 1'b1;
    @(negedge clk_sys);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_sd_wr", 64'(sd_wr), 64'd0);
    chk("abort_bk_ena", 64'(bk_ena), 64'd0);
    repeat (3) @(negedge clk_sys);
    chk("abort_no_bk_reset", 64'(rst_cycles), 64'd0);
    chk("abort_req_left", 64'(exp_q.size()), 64'd0);
    dl_active = 1'b0;
    sd_auto = 1'b1;
    exp_q.delete();

    // Asynchronous reset in XFER of sector 2
    ack_len = 20;
    rst_cycles = 0;
    push_seq(1'b0, 0, 16);
    do_mount(32'd8192);
    t = 0;
    while (!(sect == 4'd2 && sd_ack && !sd_rd) && t < 400) begin
      @(negedge clk_sys);
      t++;
    end
    chk("xfer_reached", 64'(sect == 4'd2 && sd_ack && !sd_rd), 64'd1);
    #2 RESET_n = 1'b0;
    #1;
    chk("arst_sd_rd", 64'(sd_rd), 64'd0);
    chk("arst_sd_wr", 64'(sd_wr), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_bk_ena", 64'(bk_ena), 64'd0);
    chk("arst_sect", 64'(sect), 64'd0);
    chk("arst_sd_lba", 64'(sd_lba), 64'd0);
    chk("arst_bk_reset", 64'(bk_reset), 64'd0);
    exp_q.delete();
    @(negedge clk_sys);
    RESET_n = 1'b1;
    t = 0;
    while (sd_ack && t < 100) begin
      @(negedge clk_sys);
      t++;
    end
    repeat (5) @(negedge clk_sys);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_sd_rd", 64'(sd_rd), 64'd0);
    chk("post_rst_bk_reset", 64'(rst_cycles), 64'd0);
    chk("post_rst_bk_ena", 64'(bk_ena), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
